systolic_skew_feeder: RTL and testbench
=======================================

# systolic_skew_feeder

Input stage directly upstream of the systolic array core. Accepts one k-slice per handshake: column k of A (`array_height_p` elements) and row k of B (`array_width_p` elements). It emits them onto the array's west and north edges with diagonal skew: lane i is delayed i extra cycles. It counts `depth_p` slices per matrix product, then drains the skew pipelines and reports completion before accepting the next product.

## Interface
- `width_p`, 8, element width in bits
- `array_width_p`, 2, array columns (B lanes)
- `array_height_p`, 2, array rows (A lanes)
- `depth_p`, 2, inner dimension K (slices per product), ≥1
- `clk_i`  in  1  clock
- `reset_i`  in  1  reset; synchronous, active-high
- `en_i`  in  1  global advance; low freezes all state
- `flush_i`  in  1  synchronous abort; clears pipelines, counters, FSM
- `valid_i`  in  1  slice present
- `ready_o`  out  1  slice accepted when `valid_i & ready_o` at posedge
- `a_i`  in  `array_height_p*width_p`  A column slice; lane r at `[r*width_p +: width_p]`
- `b_i`  in  `array_width_p*width_p`  B row slice; lane c likewise
- `row_data_o`  out  `array_height_p*width_p`  west-edge data, lane r
- `row_valid_o`  out  `array_height_p`  west-edge valid per lane
- `col_data_o`  out  `array_width_p*width_p`  north-edge data, lane c
- `col_valid_o`  out  `array_width_p`  north-edge valid per lane
- `done_o`  out  1  one-cycle pulse: last slice visible on deepest lane

## Operation
- L = max(`array_height_p`, `array_width_p`) − 1, the deepest lane index.
- Lane i is a chain of i+1 registers (data + valid), all advancing only when `en_i` = 1.
- Stage 0 of every lane loads on accept. On no accept it loads valid = 0 and data is don't-care; bench compares data only when valid.
- FSM states:
  - FEED: `ready_o = en_i`. Each accept increments `k_cnt`. An accept with `k_cnt` = `depth_p`−1 wraps `k_cnt` to 0, loads `drain_cnt` = L and moves to DRAIN.
  - DRAIN: `ready_o` = 0. `drain_cnt` decrements each `en_i` cycle. `done_o = en_i & (drain_cnt == 0)`. Next enabled edge with `drain_cnt` = 0 returns to FEED.
- `flush_i` or `reset_i`:
  - All valid bits, data, `k_cnt` and `drain_cnt` go to 0; state goes to FEED.
  - Takes effect regardless of `en_i`.
  - `ready_o` = 0 in that cycle, so any `valid_i` is dropped.
- `reset_i` has priority over `flush_i`, with identical effect.
- Bubbles (`valid_i` = 0 in FEED) propagate as valid = 0 diagonally and do not advance `k_cnt`.
- No output backpressure: the array consumes edge data every enabled cycle.

## Timing
- Reset values: `ready_o` 0, all `*_valid_o` 0, all `*_data_o` 0, `done_o` 0.
- Slice accepted at edge t appears on lane i at cycle t+1+i.
- `done_o` is asserted in cycle t_last+1+L, where t_last is the edge that accepted the final slice. It is simultaneous with the final slice on the deepest lane.
- First cycle `ready_o` can be 1 again: t_last+2+L.
- `en_i` low: outputs hold their values and `ready_o` = 0; `done_o` is not asserted and is not lost, it fires on the first enabled cycle.
- `depth_p` = 1: every accept enters DRAIN.
- `array_height_p ≠ array_width_p`: the shorter side's lanes finish early and show valid = 0 thereafter.

## Structure
- Shared package `systolic_pkg` holds:
  - `feed_state_e` enum {FEED, DRAIN}
  - a `max_int` function used for L
  - `$clog2`-based widths for `k_cnt` and `drain_cnt`
- Sub-module `skew_delay_line`:
  - parameters `width_p`, `delay_p`; ports clock, reset, en, clear, valid/data in/out
  - instantiated once per lane with `delay_p` = lane index + 1
- Top: generate loops over lanes, plus the FSM and counters.

## Test plan
- Reset: hold `reset_i` 10 cycles with `valid_i` = 1. Required: `ready_o`, all valids and `done_o` stay 0. First cycle after release, `ready_o` = 1.
- 2×2, K=2, back-to-back slices a=(1,2)/b=(5,6), then a=(3,4)/b=(7,8), accepted at edges 0 and 1. Required:
  - `row_data` lane0 = 1@c1, 3@c2; lane1 = 2@c2, 4@c3
  - columns likewise with 5,6,7,8
  - `done_o` at c3; `ready_o` 0 at c2–c3, 1 at c4
- Bubble: one idle cycle between the two slices. Required: lane0 valid pattern 1,0,1; `done_o` delayed one cycle versus the previous case.
- Stall: drop `en_i` for 3 cycles mid-DRAIN. Required: outputs and counters frozen, `ready_o` 0, exactly one `done_o` pulse after resume.
- Flush: assert `flush_i` after the first slice of K=2. Required:
  - next cycle all valids 0, state FEED, `k_cnt` 0
  - a following 2-slice product completes normally
- Non-square: H=3, W=1, K=1, single slice. Required: col lane0 valid only at c1; row lane2 at c3; `done_o` at c3.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array front end.
// Provides the feeder FSM encoding and the width helpers its counters use.
package systolic_pkg;

    typedef enum logic {
        FEED  = 1'b0,
        DRAIN = 1'b1
    } feed_state_e;

    function automatic int unsigned max_int(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Slice handshake in, skewed west/north edge data out.
// The master drives slices; the slave is the feeder.
interface systolic_skew_feeder_if #(
    parameter int unsigned width_p        = 8,
    parameter int unsigned array_width_p  = 2,
    parameter int unsigned array_height_p = 2
);
    logic                                valid_i;
    logic                                ready_o;
    logic [array_height_p*width_p-1:0]   a_i;
    logic [array_width_p*width_p-1:0]    b_i;
    logic [array_height_p*width_p-1:0]   row_data_o;
    logic [array_height_p-1:0]           row_valid_o;
    logic [array_width_p*width_p-1:0]    col_data_o;
    logic [array_width_p-1:0]            col_valid_o;
    logic                                done_o;

    modport master (
        output valid_i, a_i, b_i,
        input  ready_o, row_data_o, row_valid_o, col_data_o, col_valid_o, done_o
    );

    modport slave (
        input  valid_i, a_i, b_i,
        output ready_o, row_data_o, row_valid_o, col_data_o, col_valid_o, done_o
    );

endinterface

// File: rtl/skew_delay_line.sv
// One feeder lane: a delay_p-deep register chain for data and valid.
// Everything advances only on enable; reset and clear zero the whole chain.
module skew_delay_line #(
    parameter int unsigned width_p = 8,
    parameter int unsigned delay_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               clear_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               valid_o,
    output logic [width_p-1:0] data_o
);

    logic [delay_p-1:0]              valid_q;
    logic [delay_p-1:0][width_p-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            valid_q <= '0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int unsigned s = 1; s < delay_p; s++) begin
                valid_q[s] <= valid_q[s-1];
                data_q[s]  <= data_q[s-1];
            end
        end
    end

    assign valid_o = valid_q[delay_p-1];
    assign data_o  = data_q[delay_p-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonal-skew input stage for the systolic array: lane i lags by i cycles.
// Counts depth_p slices per product, then drains the skew before taking more.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned width_p        = 8,
    parameter int unsigned array_width_p  = 2,
    parameter int unsigned array_height_p = 2,
    parameter int unsigned depth_p        = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    input  logic                   flush_i,
    systolic_skew_feeder_if.slave  bus
);

    localparam int unsigned lanes_c     = max_int(array_height_p, array_width_p);
    localparam int unsigned last_lane_c = lanes_c - 1;
    localparam int unsigned k_w         = cnt_width(depth_p);
    localparam int unsigned d_w         = cnt_width(lanes_c);

    feed_state_e    state_q, state_d;
    logic [k_w-1:0] k_cnt_q, k_cnt_d;
    logic [d_w-1:0] drain_cnt_q, drain_cnt_d;
    logic           ready;
    logic           done;
    logic           accept;

    logic [array_height_p-1:0]         row_valid;
    logic [array_height_p*width_p-1:0] row_data;
    logic [array_width_p-1:0]          col_valid;
    logic [array_width_p*width_p-1:0]  col_data;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            state_q     <= FEED;
            k_cnt_q     <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            k_cnt_q     <= k_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Enable gating lives here, so a low en_i leaves every _d equal to its _q.
    always_comb begin
        state_d     = state_q;
        k_cnt_d     = k_cnt_q;
        drain_cnt_d = drain_cnt_q;
        ready       = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            FEED: begin
                ready = en_i & ~flush_i & ~reset_i;
                if (ready && bus.valid_i) begin
                    if (k_cnt_q == k_w'(depth_p - 1)) begin
                        k_cnt_d     = '0;
                        drain_cnt_d = d_w'(last_lane_c);
                        state_d     = DRAIN;
                    end else begin
                        k_cnt_d = k_cnt_q + k_w'(1);
                    end
                end
            end
            DRAIN: begin
                done = en_i & ~reset_i & (drain_cnt_q == '0);
                if (en_i) begin
                    if (drain_cnt_q == '0) begin
                        state_d = FEED;
                    end else begin
                        drain_cnt_d = drain_cnt_q - d_w'(1);
                    end
                end
            end
            default: state_d = FEED;
        endcase
    end

    assign accept = ready & bus.valid_i;

    genvar r;
    generate
        for (r = 0; r < array_height_p; r++) begin : g_row
            skew_delay_line #(
                .width_p (width_p),
                .delay_p (r + 1)
            ) u_line (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .en_i    (en_i),
                .clear_i (flush_i),
                .valid_i (accept),
                .data_i  (bus.a_i[r*width_p +: width_p]),
                .valid_o (row_valid[r]),
                .data_o  (row_data[r*width_p +: width_p])
            );
        end
    endgenerate

    genvar c;
    generate
        for (c = 0; c < array_width_p; c++) begin : g_col
            skew_delay_line #(
                .width_p (width_p),
                .delay_p (c + 1)
            ) u_line (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .en_i    (en_i),
                .clear_i (flush_i),
                .valid_i (accept),
                .data_i  (bus.b_i[c*width_p +: width_p]),
                .valid_o (col_valid[c]),
                .data_o  (col_data[c*width_p +: width_p])
            );
        end
    endgenerate

    assign bus.ready_o     = ready;
    assign bus.done_o      = done;
    assign bus.row_valid_o = row_valid;
    assign bus.row_data_o  = row_data;
    assign bus.col_valid_o = col_valid;
    assign bus.col_data_o  = col_data;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: 2x2/K=2 instance with random and
// directed traffic, plus a 3x1/K=1 instance checked against fixed tables.
module tb_systolic_skew_feeder;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 2;
    localparam int unsigned C  = 2;
    localparam int unsigned K  = 2;
    localparam int unsigned L  = 1;
    localparam int unsigned NL = H + C;

    typedef struct packed {
        logic [W-1:0] d;
        int           due;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic flush;

    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.width_p(W), .array_width_p(C), .array_height_p(H)) bus0();
    systolic_skew_feeder_if #(.width_p(W), .array_width_p(1), .array_height_p(3)) bus1();

    systolic_skew_feeder #(
        .width_p(W), .array_width_p(C), .array_height_p(H), .depth_p(K)
    ) dut0 (
        .clk_i(clk), .reset_i(rst), .en_i(en), .flush_i(flush), .bus(bus0)
    );

    systolic_skew_feeder #(
        .width_p(W), .array_width_p(1), .array_height_p(3), .depth_p(1)
    ) dut1 (
        .clk_i(clk), .reset_i(rst), .en_i(en), .flush_i(1'b0), .bus(bus1)
    );

    // Model: per-lane queues of expected slices stamped with the enabled-edge
    // count at which they must appear; done_q holds the pending done stamp.
    item_t lq[NL][$];
    int    done_q[$];
    int    ecount;
    int    kpos;
    bit    fresh;
    bit    mon_on;
    int    n_cmp;
    int    n_err;
    int    n_done_exp;
    int    n_done_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic lane_v(input int i);
        return (i < int'(H)) ? bus0.row_valid_o[i] : bus0.col_valid_o[i-int'(H)];
    endfunction

    function automatic logic [W-1:0] lane_d(input int i);
        return (i < int'(H)) ? bus0.row_data_o[i*int'(W) +: W]
                             : bus0.col_data_o[(i-int'(H))*int'(W) +: W];
    endfunction

    // One clock of stimulus for dut0; model updated at the edge it drives into.
    task automatic step(input logic v, input logic [H*W-1:0] a, input logic [C*W-1:0] b,
                        input logic e, input logic f);
        logic acc;
        bus0.valid_i = v;
        bus0.a_i     = a;
        bus0.b_i     = b;
        en           = e;
        flush        = f;
        acc = e && !f && !rst && v && (done_q.size() == 0);
        @(posedge clk);
        if (rst || f) begin
            for (int i = 0; i < int'(NL); i++) lq[i].delete();
            done_q.delete();
            kpos  = 0;
            fresh = 1'b1;
        end else if (e) begin
            if (done_q.size() != 0 && done_q[0] == ecount) void'(done_q.pop_front());
            ecount++;
            if (acc) begin
                for (int i = 0; i < int'(NL); i++) begin
                    item_t it;
                    it.d   = (i < int'(H)) ? a[i*int'(W) +: W] : b[(i-int'(H))*int'(W) +: W];
                    it.due = ecount + ((i < int'(H)) ? i : i - int'(H));
                    lq[i].push_back(it);
                end
                kpos++;
                if (kpos == int'(K)) begin
                    kpos = 0;
                    done_q.push_back(ecount + int'(L));
                end
            end
            fresh = 1'b1;
        end else begin
            fresh = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    // Monitor: compares dut0 outputs against the model once per cycle.
    logic [NL-1:0]   prev_v;
    logic [H*W-1:0]  prev_rd;
    logic [C*W-1:0]  prev_cd;

    always @(negedge clk) begin
        if (mon_on) begin
            logic exp_done;
            exp_done = en && !rst && done_q.size() != 0 && done_q[0] == ecount;
            check("ready", 32'(bus0.ready_o), 32'(en && !flush && !rst && done_q.size() == 0));
            check("done", 32'(bus0.done_o), 32'(exp_done));
            n_done_exp  += int'(exp_done);
            n_done_seen += int'(bus0.done_o);
            if (fresh) begin
                for (int i = 0; i < int'(NL); i++) begin
                    logic exp_v;
                    exp_v = lq[i].size() != 0 && lq[i][0].due == ecount;
                    check($sformatf("lane%0d_valid", i), 32'(lane_v(i)), 32'(exp_v));
                    if (exp_v) begin
                        item_t it;
                        it = lq[i].pop_front();
                        if (lane_v(i)) check($sformatf("lane%0d_data", i), 32'(lane_d(i)), 32'(it.d));
                    end
                end
            end else begin
                for (int i = 0; i < int'(NL); i++)
                    check($sformatf("lane%0d_hold_valid", i), 32'(lane_v(i)), 32'(prev_v[i]));
                check("hold_row_data", 32'(bus0.row_data_o), 32'(prev_rd));
                check("hold_col_data", 32'(bus0.col_data_o), 32'(prev_cd));
            end
            for (int i = 0; i < int'(NL); i++) prev_v[i] = lane_v(i);
            prev_rd = bus0.row_data_o;
            prev_cd = bus0.col_data_o;
        end
    end

    logic [H*W-1:0] a1, a2;
    logic [C*W-1:0] b1, b2;
    logic [2:0]     nsq_rv [4];
    logic           nsq_cv [4];
    logic           nsq_dn [4];
    logic           nsq_rd [4];

    initial begin
        rst          = 1'b1;
        en           = 1'b1;
        flush        = 1'b0;
        bus0.valid_i = 1'b0;
        bus0.a_i     = '0;
        bus0.b_i     = '0;
        bus1.valid_i = 1'b0;
        bus1.a_i     = '0;
        bus1.b_i     = '0;
        ecount = 0; kpos = 0; fresh = 1'b0; mon_on = 1'b0;
        n_cmp = 0; n_err = 0; n_done_exp = 0; n_done_seen = 0;
        a1 = {8'd2, 8'd1}; b1 = {8'd6, 8'd5};
        a2 = {8'd4, 8'd3}; b2 = {8'd8, 8'd7};
        nsq_rv = '{3'b001, 3'b010, 3'b100, 3'b000};
        nsq_cv = '{1'b1, 1'b0, 1'b0, 1'b0};
        nsq_dn = '{1'b0, 1'b0, 1'b1, 1'b0};
        nsq_rd = '{1'b0, 1'b0, 1'b0, 1'b1};

        // Reset held with valid asserted: nothing may be accepted.
        step(1'b1, a1, b1, 1'b1, 1'b0);
        mon_on = 1'b1;
        for (int i = 0; i < 9; i++) step(1'b1, H*W'($urandom), C*W'($urandom), 1'b1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_row_data", 32'(bus0.row_data_o), 32'd0);
        check("reset_col_data", 32'(bus0.col_data_o), 32'd0);
        check("reset_done1", 32'(bus1.done_o), 32'd0);

        // Back-to-back product, then the same with a bubble.
        step(1'b1, a1, b1, 1'b1, 1'b0);
        step(1'b1, a2, b2, 1'b1, 1'b0);
        idle(3);
        step(1'b1, a1, b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, a2, b2, 1'b1, 1'b0);
        idle(3);

        // Stall for three cycles while draining.
        step(1'b1, a1, b1, 1'b1, 1'b0);
        step(1'b1, a2, b2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, a1, b1, 1'b0, 1'b0);
        idle(3);

        // Flush after the first slice, then a complete product.
        step(1'b1, a1, b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        step(1'b1, a2, b2, 1'b1, 1'b0);
        step(1'b1, a1, b1, 1'b1, 1'b0);
        idle(3);

        // Random traffic: valid, enable and rare flushes.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, H*W'($urandom), C*W'($urandom),
                 $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0);
        end
        idle(4);

        // Non-square 3x1, K=1 instance: single slice against fixed tables.
        bus1.valid_i = 1'b1;
        bus1.a_i     = {8'h33, 8'h22, 8'h11};
        bus1.b_i     = 8'h44;
        @(negedge clk);
        check("nsq_ready_c0", 32'(bus1.ready_o), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        bus1.valid_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("nsq_row_valid_c%0d", c), 32'(bus1.row_valid_o), 32'(nsq_rv[c-1]));
            check($sformatf("nsq_col_valid_c%0d", c), 32'(bus1.col_valid_o), 32'(nsq_cv[c-1]));
            check($sformatf("nsq_done_c%0d", c), 32'(bus1.done_o), 32'(nsq_dn[c-1]));
            check($sformatf("nsq_ready_c%0d", c), 32'(bus1.ready_o), 32'(nsq_rd[c-1]));
            if (c <= 3)
                check($sformatf("nsq_row_data_c%0d", c), 32'(bus1.row_data_o[(c-1)*8 +: 8]),
                      32'(8'h11 * c));
            if (c == 1)
                check("nsq_col_data_c1", 32'(bus1.col_data_o), 32'h44);
            step(1'b0, '0, '0, 1'b1, 1'b0);
        end

        mon_on = 1'b0;
        check("done_pulse_count", 32'(n_done_seen), 32'(n_done_exp));
        for (int i = 0; i < int'(NL); i++)
            check($sformatf("lane%0d_leftover", i), 32'(lq[i].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
